vram: RTL

Dual-port 128×8 video memory that sits directly upstream of the VGA timing generator. It supplies `vdata` for the generator's `vaddr`, gives the CPU bus read/write access to the window 0x80–0xFF, and includes a fill engine that paints every cell with one RRGGBB colour. The fill engine clears the screen automatically after reset.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vram_dpram.sv | 43 ++++
 rtl/vram.sv | 116 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the video path: framebuffer geometry, colour format
// and the fill engine state encoding.
package vga_pkg;

    localparam int VRAM_DEPTH   = 128;
    localparam int VRAM_WIN_BIT = 7;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } vram_state_t;

endpackage

// File: rtl/vram_dpram.sv
// Framebuffer storage: one synchronous write port and two registered read ports.
// Both read ports see the old contents when reading a cell written on the same edge.
module vram_dpram
    import vga_pkg::*;
#(
    parameter int DEPTH = VRAM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          a_en,
    input  logic          a_zero,
    input  logic [AW-1:0] a_addr,
    output logic [7:0]    a_data,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Port A only updates on an accepted CPU read and returns zero for misses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_data <= 8'h00;
            b_data <= 8'h00;
        end else begin
            b_data <= mem[b_addr];
            if (a_en) begin
                a_data <= a_zero ? 8'h00 : mem[a_addr];
            end
        end
    end

endmodule

// File: rtl/vram.sv
// Video memory feeding the VGA timing generator: CPU window access, display
// read port and a fill engine that also clears the screen after reset.
module vram
    import vga_pkg::*;
#(
    parameter int DEPTH    = VRAM_DEPTH,
    parameter int BASE_BIT = VRAM_WIN_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic [7:0] cpu_rdata,
    input  logic       fill_start,
    input  logic [5:0] fill_color,
    output logic       fill_busy,
    output logic       fill_done,
    input  logic [7:0] vaddr,
    output logic [7:0] vdata
);

    localparam int AW = $clog2(DEPTH);

    vram_state_t   state, state_n;
    logic [AW-1:0] fill_idx, idx_n;
    rgb222_t       fill_col, col_n;
    logic          done_n;

    logic          cpu_hit;
    logic          cpu_accept;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          unused_vaddr;

    assign unused_vaddr = vaddr[7];

    assign cpu_hit    = cpu_addr[BASE_BIT];
    assign cpu_ready  = ~cpu_hit | (state == IDLE);
    assign cpu_accept = cpu_req & cpu_ready;
    assign fill_busy  = (state == FILL);

    // Reset lands in FILL with black so every reset clears the screen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            fill_idx  <= '0;
            fill_col  <= '0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_n;
            fill_idx  <= idx_n;
            fill_col  <= col_n;
            fill_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = fill_idx;
        col_n   = fill_col;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_n = FILL;
                    idx_n   = '0;
                    col_n   = rgb222_t'(fill_color);
                end
            end
            FILL: begin
                idx_n = fill_idx + AW'(1);
                if (fill_idx == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The fill engine owns the write port; CPU hits are stalled while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr[AW-1:0];
        mem_wdata = cpu_wdata;
        if (state == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = fill_idx;
            mem_wdata = {2'b00, fill_col};
        end else if (cpu_accept && cpu_we && cpu_hit) begin
            mem_we = 1'b1;
        end
    end

    vram_dpram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .a_en   (cpu_accept & ~cpu_we),
        .a_zero (~cpu_hit),
        .a_addr (cpu_addr[AW-1:0]),
        .a_data (cpu_rdata),
        .b_addr (vaddr[AW-1:0]),
        .b_data (vdata)
    );

endmodule
